// File: rtl/eight_div_pkg.sv
// ---------------------------------------------------------------------------
// eight_div_pkg : shared widths, iteration count and FSM states for the divider
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package eight_div_pkg;

  localparam int DIV_WIDTH  = 8;
  localparam int ITERATIONS = 8;
  localparam int CNT_W      = $clog2(ITERATIONS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/eight_sub_module.sv
// ---------------------------------------------------------------------------
// eight_sub_module : 9-bit trial subtraction for one restoring-division step
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module eight_sub_module
  import eight_div_pkg::*;
(
  input  logic [DIV_WIDTH:0]   minuend,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH:0]   diff,
  output logic                 non_neg
);

  // One guard bit above the 9-bit result acts as the borrow.
  logic [DIV_WIDTH+1:0] full_diff;

  assign full_diff = {1'b0, minuend} - {2'b00, divisor};
  assign diff      = full_diff[DIV_WIDTH:0];
  assign non_neg   = ~full_diff[DIV_WIDTH+1];

endmodule

`default_nettype wire

// File: rtl/eight_div_module.sv
// ---------------------------------------------------------------------------
// eight_div_module : 8-bit unsigned restoring divider, one quotient bit/cycle
// Optional macro DIV_ZERO_ERR_EN adds the err port and a divide-by-zero bypass
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module eight_div_module
  import eight_div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] a,
  input  logic [DIV_WIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [DIV_WIDTH-1:0] quot,
  output logic [DIV_WIDTH-1:0] rem
`ifdef DIV_ZERO_ERR_EN
  ,
  output logic                 err
`endif
);

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] dvd_q, dvd_d;
  logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
  logic [DIV_WIDTH-1:0] part_q, part_d;
  logic [DIV_WIDTH-1:0] qwork_q, qwork_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DIV_WIDTH-1:0] quot_q, quot_d;
  logic [DIV_WIDTH-1:0] rem_q, rem_d;
`ifdef DIV_ZERO_ERR_EN
  logic                 err_q, err_d;
`endif

  logic [DIV_WIDTH:0]   shifted;
  logic [DIV_WIDTH:0]   diff;
  logic                 non_neg;
  logic [DIV_WIDTH-1:0] next_part;
  logic                 unused_top_bits;

  assign shifted = {part_q, dvd_q[DIV_WIDTH-1]};

  eight_sub_module u_sub (
    .minuend (shifted),
    .divisor (dvs_q),
    .diff    (diff),
    .non_neg (non_neg)
  );

  // The partial remainder always fits in 8 bits, so bit 8 is only a carry-out.
  assign next_part       = non_neg ? diff[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];
  assign unused_top_bits = ^{diff[DIV_WIDTH], shifted[DIV_WIDTH]};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    qwork_d = qwork_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIV_ZERO_ERR_EN
    err_d   = err_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dvd_d   = a;
          dvs_d   = b;
          part_d  = '0;
          qwork_d = '0;
          cnt_d   = '0;
          state_d = S_CALC;
`ifdef DIV_ZERO_ERR_EN
          if (b == '0) begin
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = a;
            err_d   = 1'b1;
          end
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        part_d  = next_part;
        qwork_d = {qwork_q[DIV_WIDTH-2:0], non_neg};
        dvd_d   = {dvd_q[DIV_WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
          state_d = S_DONE;
          quot_d  = {qwork_q[DIV_WIDTH-2:0], non_neg};
          rem_d   = next_part;
`ifdef DIV_ZERO_ERR_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      qwork_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIV_ZERO_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      qwork_q <= qwork_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef DIV_ZERO_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;
`ifdef DIV_ZERO_ERR_EN
  assign err  = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_eight_div_module.sv
// ---------------------------------------------------------------------------
// tb_eight_div_module : self-checking bench for eight_div_module
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_eight_div_module;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a     = 8'd0;
  logic [7:0] b     = 8'd0;
  wire        busy;
  wire        done;
  wire  [7:0] quot;
  wire  [7:0] rem;
`ifdef DIV_ZERO_ERR_EN
  wire        err;
  localparam bit ZERO_SHORT = 1'b1;
`else
  localparam bit ZERO_SHORT = 1'b0;
`endif

  eight_div_module dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .quot  (quot),
    .rem   (rem)
`ifdef DIV_ZERO_ERR_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result: plain integer division; divide-by-zero gives all-ones, rem=a.
  function automatic logic [15:0] ref_div(input logic [7:0] x, input logic [7:0] y);
    if (y == 8'd0) return {8'hFF, x};
    return {8'(x / y), 8'(x % y)};
  endfunction

  // Behavioural model: a countdown of cycles until the pending result appears.
  int         m_cd   = 0;
  logic [7:0] m_pq   = 8'd0;
  logic [7:0] m_pr   = 8'd0;
  logic       e_busy = 1'b0;
  logic       e_done = 1'b0;
  logic [7:0] e_quot = 8'd0;
  logic [7:0] e_rem  = 8'd0;
  logic       e_err  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cd   <= 0;
      m_pq   <= 8'd0;
      m_pr   <= 8'd0;
      e_busy <= 1'b0;
      e_done <= 1'b0;
      e_quot <= 8'd0;
      e_rem  <= 8'd0;
      e_err  <= 1'b0;
    end else if (m_cd != 0) begin
      m_cd <= m_cd - 1;
      if (m_cd == 1) begin
        e_busy <= 1'b0;
        e_done <= 1'b1;
        e_quot <= m_pq;
        e_rem  <= m_pr;
        e_err  <= 1'b0;
      end else begin
        e_done <= 1'b0;
      end
    end else if (start) begin
      if (ZERO_SHORT && b == 8'd0) begin
        e_busy <= 1'b0;
        e_done <= 1'b1;
        e_quot <= 8'hFF;
        e_rem  <= a;
        e_err  <= 1'b1;
      end else begin
        m_cd   <= 8;
        m_pq   <= ref_div(a, b)[15:8];
        m_pr   <= ref_div(a, b)[7:0];
        e_busy <= 1'b1;
        e_done <= 1'b0;
      end
    end else begin
      e_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", busy, e_busy);
    check("cyc_done", done, e_done);
    check("cyc_quot", quot, e_quot);
    check("cyc_rem",  rem,  e_rem);
`ifdef DIV_ZERO_ERR_EN
    check("cyc_err",  err,  e_err);
`endif
  end

  // Waits for done; latency counts cycles after the start edge (start-edge cycle = 1).
  task automatic wait_done(input int s, output int lat, output logic [7:0] q, output logic [7:0] r);
    lat = -1;
    q   = 8'd0;
    r   = 8'd0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc - s + 1;
        q   = quot;
        r   = rem;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, input bit imm,
                        output int lat, output logic [7:0] q, output logic [7:0] r);
    int s;
    if (imm) #1;
    else begin
      @(posedge clk);
      #2;
    end
    a     = aa;
    b     = bb;
    start = 1'b1;
    @(posedge clk);
    #2;
    s     = cyc;
    start = 1'b0;
    wait_done(s, lat, q, r);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    int         s;
    logic [7:0] q, r;
    logic [7:0] ra, rb;

    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quot", quot, 0);
    check("reset_rem",  rem,  0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op(8'd200, 8'd7, 1'b0, lat, q, r);
    check("r027_lat",  lat, 9);
    check("r027_quot", q, 28);
    check("r027_rem",  r, 4);

    run_op(8'd255, 8'd1, 1'b0, lat, q, r);
    check("r028a_lat",  lat, 9);
    check("r028a_quot", q, 255);
    check("r028a_rem",  r, 0);
    run_op(8'd5, 8'd9, 1'b1, lat, q, r);
    check("r028b_lat",  lat, 9);
    check("r028b_quot", q, 0);
    check("r028b_rem",  r, 5);

    run_op(8'd100, 8'd0, 1'b0, lat, q, r);
    check("r029_lat",  lat, ZERO_SHORT ? 1 : 9);
    check("r029_quot", q, 255);
    check("r029_rem",  r, 100);
`ifdef DIV_ZERO_ERR_EN
    check("r029_err",  err, 1);
    run_op(8'd10, 8'd3, 1'b0, lat, q, r);
    check("err_clear", err, 0);
`endif

    // Second start mid-calculation must be ignored.
    @(posedge clk); #2;
    a = 8'd50; b = 8'd3; start = 1'b1;
    @(posedge clk); #2;
    s = cyc; start = 1'b0; a = 8'd9; b = 8'd9;
    @(posedge clk); #2;
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(s, lat, q, r);
    check("r030_lat",  lat, 9);
    check("r030_quot", q, 16);
    check("r030_rem",  r, 2);

    // Asynchronous reset in the middle of a calculation.
    @(posedge clk); #2;
    a = 8'd77; b = 8'd5; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("r031_busy", busy, 0);
    check("r031_done", done, 0);
    check("r031_quot", quot, 0);
    check("r031_rem",  rem,  0);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #2 start = 1'b0;
    #1 rst_n = 1'b1;
    run_op(8'd77, 8'd5, 1'b0, lat, q, r);
    check("r031_lat",  lat, 9);
    check("r031_quot", q, 15);
    check("r031_rem",  r, 2);

    run_op(8'd0, 8'd5, 1'b0, lat, q, r);
    check("zero_a_quot", q, 0);
    check("zero_a_rem",  r, 0);
    run_op(8'd3, 8'd200, 1'b0, lat, q, r);
    check("b_gt_a_quot", q, 0);
    check("b_gt_a_rem",  r, 3);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      run_op(ra, rb, 1'b0, lat, q, r);
      check("rand_ident", int'(q) * int'(rb) + int'(r), int'(ra));
      check("rand_rem_lt_b", (r < rb) ? 1 : 0, 1);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/eight_div_module.md
EIGHT_DIV_MODULE -- requirements
Module: eight_div_module

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a division, sampled on clk rising edge.
REQ-004 SHALL have port a, input, 8 bits: unsigned dividend, captured with accepted start.
REQ-005 SHALL have port b, input, 8 bits: unsigned divisor, captured with accepted start.
REQ-006 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-008 SHALL have port quot, output, 8 bits: quotient floor(a/b), registered.
REQ-009 SHALL have port rem, output, 8 bits: remainder a mod b, registered.
REQ-010 SHALL have port err, output, 1 bit, present only with DIV_ZERO_ERR_EN: divisor-zero flag, valid with done.

Function
REQ-011 SHALL implement states IDLE, CALC, DONE.
REQ-012 SHALL accept start in IDLE or DONE, capture a and b, clear the partial remainder and bit counter, and enter CALC.
REQ-013 SHALL ignore start while in CALC; inputs a and b are don't-care after capture.
REQ-014 SHALL resolve one quotient bit per CALC cycle, MSB first, by restoring division: shift the remainder left, bring in the next dividend bit, subtract b at 9-bit width, keep the difference and set the quotient bit iff it is non-negative.
REQ-015 SHALL leave CALC after exactly 8 cycles and enter DONE; done=1 in DONE only, giving done in the 9th cycle after the start edge.
REQ-016 SHALL update quot and rem on entry to DONE and hold them until the next completion.
REQ-017 SHALL drive busy=1 exactly in CALC.
REQ-018 SHALL go from DONE to IDLE without start, or to CALC with start (back-to-back operation, no gap cycle).
REQ-019 SHALL keep all arithmetic unsigned; a=0 yields quot=0, rem=0; b>a yields quot=0, rem=a.

Reset
REQ-020 SHALL, on rst_n low at any time including mid-CALC, go to IDLE and clear busy, done, quot, rem, err, counter and working registers to 0.
REQ-021 SHALL accept no start while rst_n is low; first acceptable start is the first edge after release.

Configuration
REQ-022 SHALL compile the err port and divide-by-zero short-cut only when DIV_ZERO_ERR_EN is defined.
REQ-023 SHALL, with DIV_ZERO_ERR_EN and b=0 on accepted start, skip CALC, enter DONE on the next edge with err=1, quot=8'hFF, rem=a; otherwise err=0.
REQ-024 SHALL, without DIV_ZERO_ERR_EN, run b=0 through the normal 8-cycle algorithm, naturally yielding quot=8'hFF, rem=a.

Structure
REQ-025 SHALL take the state enum, DIV_WIDTH=8 and iteration count constant from shared package eight_div_pkg.
REQ-026 SHALL place the 9-bit trial subtraction (difference plus non-negative flag) in one combinational sub-module, eight_sub_module.

Verification
REQ-027 a=200, b=7, start for one cycle -> busy for 8 cycles, done in the 9th cycle, quot=28, rem=4.
REQ-028 a=255, b=1, then a=5, b=9 back-to-back (start in the DONE cycle) -> quot=255, rem=0, then quot=0, rem=5, with no idle cycle between.
REQ-029 a=100, b=0 -> with macro: done on the next cycle, err=1, quot=8'hFF, rem=100; without macro: done in the 9th cycle, quot=8'hFF, rem=100.
REQ-030 start pulsed again 3 cycles into a=50, b=3, with a=9, b=9 on the bus -> ignored; result quot=16, rem=2 at the original done time.
REQ-031 rst_n pulled low 4 cycles into a=77, b=5 -> all outputs 0 immediately, no done pulse; a new start after release gives quot=15, rem=2.
REQ-032 Random a, b (b≠0), 1000 runs -> quot*b+rem==a and rem<b every time.
